// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: one 32-bit load/store becomes two 16-bit async-SRAM accesses (low half, then high half).
// Latency: ready low for 2*WAIT_CYCLES+1 cycles, high in DONE; upstream freezes on ~ready. Requests are never aborted.
// Optional macro SRAM_CTRL_LAST_READ_CACHE_EN: a repeat read of the last completed word returns in the same cycle.
module mem_stage_sram_ctrl #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [15:0]            SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int W_W   = SRAM_ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             is_wr;
    logic [W_W-1:0]   w_lat;
    logic [31:0]      wdat_lat;

    logic [31:0]      off;
    logic [W_W-1:0]   w_cur;
    logic             req;
    logic             last;
    logic             hit;
    logic             start;
    logic             phase;
    logic             unused_off;

    // Word index wraps modulo the SRAM space; byte offset within the word is dropped.
    assign off        = address - BASE_ADDR;
    assign w_cur      = off[SRAM_ADDR_W:2];
    assign unused_off = ^{off[31:SRAM_ADDR_W+1], off[1:0]};

    assign req   = rd_en | wr_en;
    assign last  = (cnt == CNT_W'(WAIT_CYCLES - 1));
    assign start = (state == IDLE) && req && !hit;
    assign phase = (state == LOW) || (state == HIGH);

`ifdef SRAM_CTRL_LAST_READ_CACHE_EN
    logic           cache_vld;
    logic [W_W-1:0] cache_tag;

    assign hit = (state == IDLE) && rd_en && !wr_en && cache_vld && (cache_tag == w_cur);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_vld <= 1'b0;
            cache_tag <= '0;
        end else if (state == HIGH && last && !is_wr) begin
            cache_vld <= 1'b1;
            cache_tag <= w_lat;
        end else if (state == DONE && is_wr) begin
            cache_vld <= 1'b0;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end
            end
            LOW: begin
                if (last) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (last) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            is_wr     <= 1'b0;
            w_lat     <= '0;
            wdat_lat  <= '0;
            read_data <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Both enables high counts as a store.
            if (start) begin
                is_wr    <= wr_en;
                w_lat    <= w_cur;
                wdat_lat <= write_data;
            end
            if (state == LOW && last && !is_wr)
                read_data[15:0] <= SRAM_DQ;
            if (state == HIGH && last && !is_wr)
                read_data[31:16] <= SRAM_DQ;
        end
    end

    // Strobes decode straight from state so an async reset releases the bus at once.
    assign SRAM_ADDR = {w_lat, state == HIGH};
    assign SRAM_WE_N = !(phase && is_wr);
    assign SRAM_OE_N = !(phase && !is_wr);
    assign SRAM_DQ   = (phase && is_wr) ? ((state == HIGH) ? wdat_lat[31:16] : wdat_lat[15:0]) : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign ready = ~req | (state == DONE) | hit;

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Memory-stage data-memory controller for the ARM pipeline.
- Turns the stage's 32-bit load/store request into two 16-bit accesses on an external asynchronous SRAM.
- Holds `ready` low while an access is in progress; upstream uses `~ready` as the pipeline freeze.
- Produces the 32-bit load word that the MEM/WB register latches.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- SRAM_ADDR_W, 18: SRAM address width (16-bit words).
- WAIT_CYCLES, 2: cycles per 16-bit half access, minimum 1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  load request (MEM_R_EN).
- wr_en  in  1  store request (MEM_W_EN).
- address  in  32  byte address from the ALU result.
- write_data  in  32  store data (Val_Rm).
- read_data  out  32  registered load word.
- ready  out  1  access complete / no access pending.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  SRAM_ADDR_W  SRAM word address.
- SRAM_WE_N  out  1  write strobe, active-low.
- SRAM_OE_N  out  1  output enable, active-low.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0.

Behaviour:
- Interface (already decided): one clock, `clk`; reset `rst` is asynchronous and active-low.
- Reset values:
  - state IDLE, counter 0, read_data 0.
  - SRAM_ADDR 0, SRAM_WE_N 1, SRAM_OE_N 1, SRAM_DQ high-Z.
- Address map:
  - off = address - BASE_ADDR, 32-bit subtraction with wrap.
  - Word index w = off[SRAM_ADDR_W:2], taken modulo the address space.
  - Low half at SRAM_ADDR = {w,0}; high half at {w,1}.
  - off[1:0] is ignored.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if rd_en|wr_en, go to LOW with counter 0; else stay.
  - LOW: drive low-half address. Counter counts 0..WAIT_CYCLES-1; at WAIT_CYCLES-1, go to HIGH with counter 0.
  - HIGH: same as LOW for the high half; at WAIT_CYCLES-1, go to DONE.
  - DONE: one cycle, then IDLE unconditionally.
- ready = ~(rd_en|wr_en) | (state==DONE), combinational.
  - For a new request, ready is low for exactly 2*WAIT_CYCLES+1 cycles (the IDLE cycle, LOW and HIGH), then high for the DONE cycle.
  - The pipeline advances at the DONE edge.
- Write phases:
  - SRAM_WE_N = 0 for the whole phase; SRAM_OE_N = 1.
  - SRAM_DQ driven with write_data[15:0] in LOW and write_data[31:16] in HIGH.
- Read phases:
  - SRAM_WE_N = 1, SRAM_OE_N = 0, SRAM_DQ high-Z.
  - SRAM_DQ is sampled on the last cycle of LOW into read_data[15:0] and on the last cycle of HIGH into read_data[31:16].
  - read_data otherwise holds its value and is never modified by a write.
- Outside LOW/HIGH: SRAM_WE_N = 1, SRAM_OE_N = 1, SRAM_DQ high-Z.
- Read type and address are latched on leaving IDLE and used for the whole access.
- rd_en and wr_en both high: treated as a write.
- Request deasserted mid-access: the access runs to completion; no abort.
- Asynchronous reset mid-access: returns to IDLE immediately; the SRAM write strobe deasserts in the same instant.

Optional Feature:
- Macro: SRAM_CTRL_LAST_READ_CACHE_EN.
- When defined:
  - A valid bit and a tag (word index w) record the last completed read.
  - A read in IDLE whose w matches the tag with valid=1 is a hit: ready=1 in that same cycle, no SRAM cycle, FSM stays IDLE, read_data already holds the word.
  - Any write that reaches DONE clears valid.
  - Reset clears valid.
- When undefined: every read performs the full SRAM access.

Test Plan:
- Write at WAIT_CYCLES=2: wr_en=1, address=1032, write_data=0xDEADBEEF -> SRAM_ADDR=4 with DQ=0xBEEF and WE_N=0 for 2 cycles, then SRAM_ADDR=5 with DQ=0xDEAD for 2 cycles; ready low 5 cycles, high on the 6th.
- Read back: rd_en=1, address=1032, SRAM model holds the data above -> read_data=0xDEADBEEF in the DONE cycle; OE_N=0 only during LOW/HIGH; DQ never driven.
- Address wrap: address=1020 read -> SRAM_ADDR=(2^18-2) then (2^18-1).
- Both enables high with write_data=0x12345678 at address 1024 -> SRAM words 0/1 become 0x5678/0x1234; read_data unchanged.
- rst=0 during a write's HIGH phase -> WE_N=1, DQ high-Z, state IDLE immediately; after release, ready reflects the request and a fresh access starts.
- With SRAM_CTRL_LAST_READ_CACHE_EN: read 1032, then read 1034 -> the second read has ready=1 in its first cycle with no SRAM_OE_N pulse. Then write 1032 followed by read 1032 -> full 5-cycle access.
